// File: rtl/imm_extend_unit.sv
// Pipelined immediate extender: zero / sign / upper / branch-offset modes,
// valid/ready on both sides with a registered output stage and a one-entry skid.
module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  localparam int PAD = OUT_W - IN_W;

  // Branch mode needs two spare bits below the immediate.
  generate
    if (OUT_W < IN_W + 2) begin : g_width_check
      $error("imm_extend_unit: OUT_W must be at least IN_W+2");
    end
  endgenerate

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                               input logic [1:0]      mode);
    logic [OUT_W-1:0] sext;
    sext = {{PAD{imm[IN_W-1]}}, imm};
    case (mode)
      2'b00:   extend = {{PAD{1'b0}}, imm};
      2'b01:   extend = sext;
      2'b10:   extend = {imm, {PAD{1'b0}}};
      // Shifting the sign-extended value keeps PAD-2 sign copies without a zero-width replication.
      default: extend = sext << 2;
    endcase
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q,  out_data_d;
  logic [1:0]       out_mode_q,  out_mode_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q,  skid_data_d;
  logic [1:0]       skid_mode_q,  skid_mode_d;

  logic             in_ready_int;
  logic             in_accept;
  logic [OUT_W-1:0] in_ext;

  always_comb begin
    in_ready_int = ~skid_valid_q & ~rst;
    in_accept    = in_valid & in_ready_int;
    in_ext       = extend(in_imm, in_mode);

    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_mode_d   = out_mode_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_mode_d  = skid_mode_q;

    if (~out_valid_q | out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_mode_d   = skid_mode_q;
        skid_valid_d = 1'b0;
      end else if (in_accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_ext;
        out_mode_d  = in_mode;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_ext;
      skid_mode_d  = in_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_mode_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_mode_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_mode_q   <= out_mode_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_mode_q  <= skid_mode_d;
    end
  end

  // Outputs are forced idle while rst is high so no handshake can complete in that cycle.
  assign in_ready  = in_ready_int;
  assign out_valid = out_valid_q & ~rst;
  assign out_data  = rst ? '0 : out_data_q;
  assign out_mode  = rst ? 2'b00 : out_mode_q;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: table-driven mode vectors through a
// scoreboard queue, plus hand-written stall, simultaneous-event, reset and width-variant sequences.
module tb_imm_extend_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;

  logic        v_in_valid;
  logic        v_in_ready;
  logic [7:0]  v_in_imm;
  logic [1:0]  v_in_mode;
  logic        v_out_valid;
  logic [15:0] v_out_data;
  logic [1:0]  v_out_mode;

  always #5 clk = ~clk;

  imm_extend_unit #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
  );

  imm_extend_unit #(.IN_W(8), .OUT_W(16)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(v_in_valid), .in_ready(v_in_ready), .in_imm(v_in_imm), .in_mode(v_in_mode),
    .out_valid(v_out_valid), .out_ready(1'b1), .out_data(v_out_data), .out_mode(v_out_mode)
  );

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  mode;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          accepts = 0;
  logic [31:0] cur_exp;
  exp_t        exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: pop on output handshake, push on input handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        $display("OUT data=%h mode=%0d", out_data, out_mode);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_mode", {30'd0, out_mode}, {30'd0, e.mode});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{cur_exp, in_mode});
        accepts++;
        $display("IN  imm=%h mode=%0d", in_imm, in_mode);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  vec_t        vec[10];
  logic [15:0] v_exp[4];

  initial begin
    vec[0] = '{16'h8001, 2'b00, 32'h00008001};
    vec[1] = '{16'h8001, 2'b01, 32'hFFFF8001};
    vec[2] = '{16'h8001, 2'b10, 32'h80010000};
    vec[3] = '{16'h8001, 2'b11, 32'hFFFE0004};
    vec[4] = '{16'h7FFF, 2'b01, 32'h00007FFF};
    vec[5] = '{16'h7FFF, 2'b11, 32'h0001FFFC};
    vec[6] = '{16'h0000, 2'b01, 32'h00000000};
    vec[7] = '{16'hFFFF, 2'b10, 32'hFFFF0000};
    vec[8] = '{16'h1234, 2'b11, 32'h000048D0};
    vec[9] = '{16'h8000, 2'b11, 32'hFFFE0000};
    v_exp[0] = 16'h0080; v_exp[1] = 16'hFF80; v_exp[2] = 16'h8000; v_exp[3] = 16'hFE00;

    rst = 1'b1; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0; cur_exp = '0;
    v_in_valid = 1'b0; v_in_imm = '0; v_in_mode = '0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    next_cycle();

    // Mode sweep, full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_imm = vec[i].imm; in_mode = vec[i].mode; cur_exp = vec[i].exp;
      @(negedge clk);
      if (i > 0) check("sweep_valid", out_valid, 1);
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("sweep_valid_last", out_valid, 1);
    drain("sweep_drain");
    next_cycle();

    // Back-pressure: A into out, B into skid, C refused
    out_ready = 1'b0;
    accepts = 0;
    in_valid = 1'b1; in_imm = 16'h0001; in_mode = 2'b00; cur_exp = 32'h1;
    next_cycle();
    @(negedge clk);
    check("bp_a_out", out_data, 32'h1);
    check("bp_in_ready_a", in_ready, 1);
    in_imm = 16'h0002; cur_exp = 32'h2;
    next_cycle();
    @(negedge clk);
    check("bp_in_ready_b", in_ready, 0);
    check("bp_hold_1", out_data, 32'h1);
    in_imm = 16'h0003; cur_exp = 32'h3;
    next_cycle();
    @(negedge clk);
    check("bp_hold_2", out_data, 32'h1);
    check("bp_hold_valid", out_valid, 1);
    check("bp_c_refused", accepts, 2);
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_gap_a", out_valid, 1);
    next_cycle();
    @(negedge clk);
    check("bp_gap_b", out_valid, 1);
    check("bp_ready_back", in_ready, 1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_gap_c", out_valid, 1);
    next_cycle();
    @(negedge clk);
    check("bp_idle", out_valid, 0);
    check("bp_count", accepts, 3);
    drain("bp_drain");
    next_cycle();

    // Simultaneous output and input accept with skid empty
    in_valid = 1'b1; in_imm = 16'h0001; in_mode = 2'b00; cur_exp = 32'h1;
    next_cycle();
    in_imm = 16'hFFFF; in_mode = 2'b01; cur_exp = 32'hFFFFFFFF;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("sim_data", out_data, 32'hFFFFFFFF);
    check("sim_valid", out_valid, 1);
    check("sim_skid_empty", in_ready, 1);
    drain("sim_drain");
    next_cycle();

    // Reset while out and skid are both full
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h00AA; in_mode = 2'b00; cur_exp = 32'hAA;
    next_cycle();
    in_imm = 16'h00BB; cur_exp = 32'hBB;
    next_cycle();
    in_imm = 16'h00CC; cur_exp = 32'hCC;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_in_ready", in_ready, 0);
    next_cycle();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("after_rst_in_ready", in_ready, 1);
    check("after_rst_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      check("no_stale_data", out_valid, 0);
    end
    next_cycle();
    in_valid = 1'b1; in_imm = 16'h8001; in_mode = 2'b01; cur_exp = 32'hFFFF8001;
    next_cycle();
    in_valid = 1'b0;
    drain("post_rst_drain");

    // Width variant IN_W=8, OUT_W=16
    for (int i = 0; i < 4; i++) begin
      v_in_valid = 1'b1; v_in_imm = 8'h80; v_in_mode = 2'(i);
      next_cycle();
      v_in_valid = 1'b0;
      @(negedge clk);
      check("w8_data", {16'd0, v_out_data}, {16'd0, v_exp[i]});
      check("w8_mode", {30'd0, v_out_mode}, 32'(i));
      check("w8_valid", v_out_valid, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imm_extend_unit.md
Name: imm_extend_unit

Overview:
- Parametrised, pipelined immediate-extension unit; successor to the fixed 16->32 zero-extender.
- Takes an IN_W-bit immediate and a 2-bit mode. Produces an OUT_W-bit operand in one of four modes: zero, sign, upper (LUI) and branch offset.
- Sits between decode and the ALU operand mux.
- Uses valid/ready handshakes with a registered output and a one-entry skid buffer, so both sides can stall without losing data.

Parameters:
- IN_W, 16, immediate input width.
- OUT_W, 32, extended output width. Legal only when OUT_W >= IN_W+2; otherwise elaboration fails via a generate-time check.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream offers an immediate.
- in_ready  output  1  unit can accept this cycle.
- in_imm  input  IN_W  raw immediate.
- in_mode  input  2  extension mode, sampled with in_imm.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  OUT_W  extended result.
- out_mode  output  2  mode that produced out_data, for debug and downstream muxing.

Behaviour:
- Modes, computed combinationally on the accepted data:
  - 00 zero: {(OUT_W-IN_W) zeros, imm}.
  - 01 sign: {(OUT_W-IN_W) copies of imm[IN_W-1], imm}.
  - 10 upper: {imm, (OUT_W-IN_W) zeros}.
  - 11 branch: {(OUT_W-IN_W-2) copies of imm[IN_W-1], imm, 2'b00}.
- State: out register (out_valid, out_data, out_mode) and skid register (skid_valid, skid_data, skid_mode). Skid data is stored already extended.
- in_ready = ~skid_valid & ~rst.
- Input accept: in_valid & in_ready.
- Output accept: out_valid & out_ready.
- Per-cycle update when rst=0:
  - If ~out_valid | out_ready (output free or draining):
    - If skid_valid: out <= skid, skid_valid <= 0.
    - Else if input accepted: out <= ext(in).
    - Else: out_valid <= 0.
  - Else (output stalled) and input accepted: skid <= ext(in), skid_valid <= 1.
- Latency: an input accepted at edge N appears on out_data/out_valid after edge N, provided the output is free.
- Throughput: one result per cycle while out_ready=1.
- Stall: the first stalled cycle absorbs one extra item into the skid, then in_ready drops the next cycle.
- While out_valid=1 and out_ready=0, out_data and out_mode are held stable.
- Data order is strictly FIFO: skid contents always leave before newer input. No item is dropped or duplicated.
- Simultaneous output accept and input accept with skid empty: the new item moves straight into out, so out_valid stays 1.
- Reset values: out_valid=0, out_data=0, out_mode=0, skid_valid=0, skid_data=0, in_ready=0 while rst=1.
- Reset mid-operation: all in-flight data is discarded and no handshake completes during the rst cycle. in_ready returns to 1 the first cycle after rst deasserts.
- in_imm and in_mode are don't-care when in_valid=0.
- Nothing is captured when in_valid=1 and in_ready=0; upstream must hold its data.

Test Plan:
- Mode sweep, out_ready=1, in_imm=16'h8001, modes 00/01/10/11 on consecutive cycles -> out_data 0x00008001, 0xFFFF8001, 0x80010000, 0xFFFE0004 one cycle later, out_mode matching, out_valid high four consecutive cycles.
- Positive sign, in_imm=16'h7FFF, mode 01 -> 0x00007FFF. Mode 11 -> 0x0001FFFC.
- Back-pressure:
  - Stimulus: out_ready=0, send A=16'h0001 then B=16'h0002 (mode 00).
  - Expected while stalled: out_data holds 0x00000001; in_ready=0 from the cycle after B is accepted; a third item C is not accepted.
  - Then raise out_ready: results appear in order A, B, C with no gaps once C is accepted.
- Simultaneous events: out_valid=1, out_ready=1, skid empty, new input 16'hFFFF mode 01 -> next cycle out_data=0xFFFFFFFF, out_valid stays 1, skid_valid stays 0.
- Reset mid-stall: skid and out full, assert rst for 1 cycle -> out_valid=0, out_data=0, in_ready=0 during rst, 1 afterwards. Old data never reappears.
- Parameter variant IN_W=8, OUT_W=16: in_imm=8'h80 -> modes 00/01/10/11 give 0x0080, 0xFF80, 0x8000, 0xFE00.
